serial_word_feeder: RTL

- Parallel-in, serial-out stage that drives the single-bit serial input `w` of the team's Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts each word out MSB-first, one bit per clock.
- Inserts a programmable idle gap (w=0) between frames and counts completed frames.

---
 rtl/serial_word_feeder.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: accepts WIDTH-bit words over valid/ready and shifts them out MSB-first on w,
// with an idle gap between frames. Optional macro SER_PARITY_EN appends an even-parity bit.
module serial_word_feeder #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

`ifdef SER_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned BIT_W    = $clog2(FRAME_LEN);
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t               state;
    logic [FRAME_LEN-1:0] shreg;
    logic [BIT_W-1:0]     bit_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [FRAME_LEN-1:0] frame_c;
    logic                 accept_c;
    logic                 last_bit_c;

    // Frame as it will appear on w, MSB first; parity is even over the data bits.
`ifdef SER_PARITY_EN
    assign frame_c = {data_in, ^data_in};
`else
    assign frame_c = data_in;
`endif

    assign data_ready = (state == IDLE);
    assign accept_c   = data_valid & data_ready;
    assign last_bit_c = (bit_cnt == BIT_W'(FRAME_LEN - 1));

    // MSB is driven on the accept edge; shreg holds the bits still to be presented.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            w          <= 1'b0;
            w_valid    <= 1'b0;
            busy       <= 1'b0;
            words_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        shreg   <= frame_c << 1;
                        bit_cnt <= '0;
                        w       <= frame_c[FRAME_LEN-1];
                        w_valid <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        w       <= 1'b0;
                        w_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last_bit_c) begin
                        w          <= 1'b0;
                        w_valid    <= 1'b0;
                        words_sent <= words_sent + CNT_W'(1);
                        bit_cnt    <= '0;
                        gap_cnt    <= '0;
                        if (GAP_CYCLES > 0) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        w       <= shreg[FRAME_LEN-1];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                GAP: begin
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        gap_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
